encoder83_sync: RTL and testbench

Synchronous 8-to-3 encoder, the inverse of the team's active-low 3-to-8 decoder. It captures falling edges on eight active-low request lines and holds them as pending. It presents the highest-priority pending line as a 3-bit code with a valid/ready handshake. Code mapping matches the decoder: line k asserted (low) encodes to code = 7 − k (bitwise ~k), so decoding the emitted code drives line k low again.

---
 rtl/encoder83_sync.sv | 147 ++++++++++++++
 tb/tb_encoder83_sync.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/encoder83_sync.sv
// encoder83_sync
// Synchronous 8-to-3 priority encoder. It is the inverse of the active-low
// 3-to-8 decoder.
//
// Falling edges on the active-low request lines are captured as pending
// bits. The highest-priority pending line is the lowest index. It is
// presented as code = ~k (7 - k) on a valid/ready output handshake.
//
// Handshake: a transfer happens at a rising edge where out_valid and
// out_ready are both high. Once raised, out_valid and code hold stable until
// that transfer completes. Only reset can drop out_valid without a transfer.
// out_ready may change freely and has no combinational path to any output.
//
// Optional feature: define ENC83_OVF_EN to add the sticky lost-request flag
// (ovf) and its synchronous clear (ovf_clr).
//
// Ports:
//   clk        in   1  clock, rising edge
//   rst_n      in   1  asynchronous active-low reset
//   req_n      in   8  request lines, active-low, synchronous to clk
//   out_ready  in   1  consumer accepts code when high with out_valid
//   code       out  3  encoded line number (~k)
//   out_valid  out  1  code is valid
//   busy       out  1  any request pending or a code being presented
//   state_dbg  out  1  FSM state (0 = IDLE, 1 = PRESENT)
//   ovf        out  1  sticky overflow (ENC83_OVF_EN only)
//   ovf_clr    in   1  synchronous clear of ovf (ENC83_OVF_EN only)

module encoder83_sync (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] req_n,
   input  logic       out_ready,
   output logic [2:0] code,
   output logic       out_valid,
   output logic       busy,
   output logic       state_dbg
`ifdef ENC83_OVF_EN
   ,
   output logic       ovf,
   input  logic       ovf_clr
`endif
);

   typedef enum logic {
      IDLE    = 1'b0,
      PRESENT = 1'b1
   } state_t;

   state_t     state, state_nxt;
   logic [7:0] req_q;
   logic [7:0] pend, pend_nxt;
   logic [7:0] fall;
   logic [7:0] clr_mask;
   logic [2:0] sel_k;
   logic [2:0] code_nxt;
   logic       valid_nxt;
   logic       accept;
   logic       armed;

   // armed is low for the first edge after reset. That edge only samples
   // req_n into req_q. A line held low through reset release then counts
   // as already low, and it must rise and fall again to raise a request.
   assign fall = armed ? (req_q & ~req_n) : 8'h00;

   assign accept = out_valid & out_ready;

   // Clear the line being handed over. Any fall in the same cycle is ORed
   // in after the clear, so a simultaneous set wins.
   always_comb begin
      clr_mask = 8'h00;
      if (accept) clr_mask[~code] = 1'b1;
   end

   assign pend_nxt = (pend & ~clr_mask) | fall;

   // Lowest pending index wins. Scanning downward lets the lowest index
   // overwrite the others.
   always_comb begin
      sel_k = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (pend[i]) sel_k = 3'(i);
      end
   end

   always_comb begin
      state_nxt = state;
      code_nxt  = code;
      valid_nxt = out_valid;
      case (state)
         IDLE: begin
            // Selection looks at the registered pend only, never this
            // cycle's fall.
            if (pend != 8'h00) begin
               code_nxt  = ~sel_k;
               valid_nxt = 1'b1;
               state_nxt = PRESENT;
            end
         end
         PRESENT: begin
            if (out_ready) begin
               valid_nxt = 1'b0;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
            valid_nxt = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         req_q     <= 8'hFF;
         armed     <= 1'b0;
         pend      <= 8'h00;
         state     <= IDLE;
         code      <= 3'd0;
         out_valid <= 1'b0;
      end else begin
         req_q     <= req_n;
         armed     <= 1'b1;
         pend      <= pend_nxt;
         state     <= state_nxt;
         code      <= code_nxt;
         out_valid <= valid_nxt;
      end
   end

   assign busy      = (|pend) | out_valid;
   assign state_dbg = state;

`ifdef ENC83_OVF_EN
   // A fall on a line that is already pending, and is not handed over in
   // the same cycle, is a lost request. A new loss beats ovf_clr.
   logic ovf_set;
   assign ovf_set = |(fall & pend & ~clr_mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        ovf <= 1'b0;
      else if (ovf_set)  ovf <= 1'b1;
      else if (ovf_clr)  ovf <= 1'b0;
   end
`endif

endmodule

// File: tb/tb_encoder83_sync.sv
module tb_encoder83_sync;

   logic       clk;
   logic       rst_n;
   logic [7:0] req_n;
   logic       out_ready;
   logic [2:0] code;
   logic       out_valid;
   logic       busy;
   logic       state_dbg;
`ifdef ENC83_OVF_EN
   logic       ovf;
   logic       ovf_clr;
`endif

   int checks = 0;
   int errors = 0;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   encoder83_sync dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_n     (req_n),
      .out_ready (out_ready),
      .code      (code),
      .out_valid (out_valid),
      .busy      (busy),
      .state_dbg (state_dbg)
`ifdef ENC83_OVF_EN
      ,
      .ovf       (ovf),
      .ovf_clr   (ovf_clr)
`endif
   );

   // Advance one rising edge. Return 1 time unit after it, where outputs
   // are sampled and inputs are driven.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      req_n     = 8'hFF;
      out_ready = 1'b0;
`ifdef ENC83_OVF_EN
      ovf_clr   = 1'b0;
`endif
      #1;
      chk("rst_valid", 8'(out_valid), 8'd0);
      chk("rst_busy",  8'(busy),      8'd0);
      chk("rst_code",  8'(code),      8'd0);
      chk("rst_state", 8'(state_dbg), 8'd0);
`ifdef ENC83_OVF_EN
      chk("rst_ovf",   8'(ovf),       8'd0);
`endif
      step(); step();
      rst_n = 1'b1;
      step();

      // Single fall on line 7 gives code 0 after 2 edges.
      req_n = 8'h7F; out_ready = 1'b1;
      step();
      chk("t1_lat_valid", 8'(out_valid), 8'd0);
      chk("t1_lat_busy",  8'(busy),      8'd1);
      step();
      chk("t1_valid", 8'(out_valid), 8'd1);
      chk("t1_code",  8'(code),      8'd0);
      chk("t1_state", 8'(state_dbg), 8'd1);
      step();
      chk("t1_acc_valid", 8'(out_valid), 8'd0);
      chk("t1_acc_busy",  8'(busy),      8'd0);
      req_n = 8'hFF; step();

      // Lines 0 and 2 fall together: code 7, an idle cycle, then code 5.
      req_n = 8'hFA; out_ready = 1'b1;
      step();
      chk("t2_lat_valid", 8'(out_valid), 8'd0);
      step();
      chk("t2_v0",   8'(out_valid), 8'd1);
      chk("t2_c0",   8'(code),      8'd7);
      step();
      chk("t2_gap_valid", 8'(out_valid), 8'd0);
      chk("t2_gap_busy",  8'(busy),      8'd1);
      step();
      chk("t2_v1",   8'(out_valid), 8'd1);
      chk("t2_c1",   8'(code),      8'd5);
      step();
      chk("t2_end_valid", 8'(out_valid), 8'd0);
      chk("t2_end_busy",  8'(busy),      8'd0);
      req_n = 8'hFF; step();

      // Line 5 stalls. A line 1 arrival does not preempt it.
      req_n = 8'hDF; out_ready = 1'b0;
      step(); step();
      chk("t3_v",  8'(out_valid), 8'd1);
      chk("t3_c",  8'(code),      8'd2);
      req_n = 8'hDD;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t3_hold_v", 8'(out_valid), 8'd1);
         chk("t3_hold_c", 8'(code),      8'd2);
      end
      out_ready = 1'b1;
      step();
      chk("t3_acc_valid", 8'(out_valid), 8'd0);
      chk("t3_acc_busy",  8'(busy),      8'd1);
      step();
      chk("t3_next_v", 8'(out_valid), 8'd1);
      chk("t3_next_c", 8'(code),      8'd6);
      step();
      chk("t3_end_valid", 8'(out_valid), 8'd0);
      chk("t3_end_busy",  8'(busy),      8'd0);
      req_n = 8'hFF; step();

      // Line 3 held low yields exactly one code 4.
      req_n = 8'hF7; out_ready = 1'b1;
      step(); step();
      chk("t4_v", 8'(out_valid), 8'd1);
      chk("t4_c", 8'(code),      8'd4);
      for (int i = 0; i < 8; i++) begin
         step();
         chk("t4_held_valid", 8'(out_valid), 8'd0);
         chk("t4_held_busy",  8'(busy),      8'd0);
      end
      req_n = 8'hFF; step();
      req_n = 8'hF7; step(); step();
      chk("t4_again_v", 8'(out_valid), 8'd1);
      chk("t4_again_c", 8'(code),      8'd4);
      step();
      chk("t4_again_end", 8'(out_valid), 8'd0);
      req_n = 8'hFF; step();

      // Reset in the middle of presenting code 3, with line 4 held low
      // across reset release.
      req_n = 8'hEF; out_ready = 1'b0;
      step(); step();
      chk("t5_v", 8'(out_valid), 8'd1);
      chk("t5_c", 8'(code),      8'd3);
      #2;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", 8'(out_valid), 8'd0);
      chk("t5_rst_busy",  8'(busy),      8'd0);
      chk("t5_rst_code",  8'(code),      8'd0);
      step();
      rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t5_held_valid", 8'(out_valid), 8'd0);
         chk("t5_held_busy",  8'(busy),      8'd0);
      end
      req_n = 8'hFF; step();
      req_n = 8'hEF; step(); step();
      chk("t5_new_v", 8'(out_valid), 8'd1);
      chk("t5_new_c", 8'(code),      8'd3);
      step();
      chk("t5_new_end", 8'(out_valid), 8'd0);
      req_n = 8'hFF; step();

`ifdef ENC83_OVF_EN
      // A repeat fall on pending line 6 sets ovf. Only one code 1 appears.
      req_n = 8'hBF; out_ready = 1'b0;
      step(); step();
      chk("t6_v", 8'(out_valid), 8'd1);
      chk("t6_c", 8'(code),      8'd1);
      chk("t6_ovf0", 8'(ovf),    8'd0);
      req_n = 8'hFF; step();
      req_n = 8'hBF; step();
      chk("t6_ovf_set", 8'(ovf), 8'd1);
      step();
      chk("t6_ovf_hold", 8'(ovf), 8'd1);
      ovf_clr = 1'b1; step();
      ovf_clr = 1'b0;
      chk("t6_ovf_clr", 8'(ovf), 8'd0);
      out_ready = 1'b1; step();
      chk("t6_acc_valid", 8'(out_valid), 8'd0);
      chk("t6_acc_busy",  8'(busy),      8'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t6_no_second", 8'(out_valid), 8'd0);
      end
      req_n = 8'hFF; step();
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
